orion_mem_arbiter: RTL and testbench

ORION_MEM_ARBITER -- requirements
Module: orion_mem_arbiter

---
 rtl/orion_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_orion_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/orion_mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single shared memory port.
// Optional macro ORION_ARB_ROUND_ROBIN_EN alternates grants on contention; otherwise data wins.
module orion_mem_arbiter #(
  parameter int unsigned ADDRW = 32,
  parameter int unsigned DATAW = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [ADDRW-1:0]     imem_addr,
  input  logic                 imem_valid,
  output logic [DATAW-1:0]     imem_rdata,
  output logic                 imem_ack,

  input  logic [ADDRW-1:0]     dmem_addr,
  input  logic                 dmem_valid,
  input  logic [DATAW-1:0]     dmem_wdata,
  input  logic [DATAW/8-1:0]   dmem_mask,
  input  logic                 dmem_we,
  output logic [DATAW-1:0]     dmem_rdata,
  output logic                 dmem_ack,

  output logic [ADDRW-1:0]     mem_addr,
  output logic                 mem_valid,
  output logic [DATAW-1:0]     mem_wdata,
  output logic [DATAW/8-1:0]   mem_mask,
  output logic                 mem_we,
  input  logic [DATAW-1:0]     mem_rdata,
  input  logic                 mem_ack,

  output logic                 busy,
  output logic                 owner_d
);

  localparam int unsigned MASKW = DATAW / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDRW-1:0]   r_addr;
  logic [ADDRW-1:0]   w_addr;
  logic [DATAW-1:0]   r_wdata;
  logic [DATAW-1:0]   w_wdata;
  logic [MASKW-1:0]   r_mask;
  logic [MASKW-1:0]   w_mask;
  logic               r_we;
  logic               w_we;
  logic               r_owner_d;
  logic               w_owner_d;
  logic               w_prio_d;

  // On contention, decide whether the data port takes the grant
`ifdef ORION_ARB_ROUND_ROBIN_EN
  assign w_prio_d = ~r_owner_d;
`else
  assign w_prio_d = 1'b1;
`endif

  // Next-state, payload capture and combinational ack/rdata steering
  always_comb begin
    w_next     = r_state;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_mask     = r_mask;
    w_we       = r_we;
    w_owner_d  = r_owner_d;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;

    case (r_state)
      IDLE: begin
        if (dmem_valid && (!imem_valid || w_prio_d)) begin
          w_next    = GRANT_D;
          w_addr    = dmem_addr;
          w_wdata   = dmem_wdata;
          w_mask    = dmem_mask;
          w_we      = dmem_we;
          w_owner_d = 1'b1;
        end else if (imem_valid) begin
          w_next    = GRANT_I;
          w_addr    = imem_addr;
          w_wdata   = '0;
          w_mask    = '1;
          w_we      = 1'b0;
          w_owner_d = 1'b0;
        end
      end
      GRANT_I: begin
        if (mem_ack) begin
          w_next     = IDLE;
          imem_ack   = 1'b1;
          imem_rdata = mem_rdata;
        end
      end
      GRANT_D: begin
        if (mem_ack) begin
          w_next     = IDLE;
          dmem_ack   = 1'b1;
          dmem_rdata = mem_rdata;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State and latched payload; reset abandons any grant in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_we      <= 1'b0;
      r_owner_d <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_mask    <= w_mask;
      r_we      <= w_we;
      r_owner_d <= w_owner_d;
    end
  end

  assign mem_valid = (r_state != IDLE);
  assign busy      = (r_state != IDLE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_mask  = r_mask;
  assign mem_we    = r_we;
  assign owner_d   = r_owner_d;

endmodule

// File: tb/tb_orion_mem_arbiter.sv
// Directed bench for orion_mem_arbiter: vector table of single transactions plus
// hand-written arbitration, reset and mid-grant sequences.
module tb_orion_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] dmem_addr;
  logic        dmem_valid;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        owner_d;

  int n_checks = 0;
  int n_errors = 0;

  orion_mem_arbiter #(.ADDRW(32), .DATAW(32)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_addr(dmem_addr), .dmem_valid(dmem_valid), .dmem_wdata(dmem_wdata), .dmem_mask(dmem_mask),
    .dmem_we(dmem_we), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .owner_d(owner_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        we;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_mask;
    logic        exp_we;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transaction, entered and left at a negedge in IDLE
  task automatic run_vec(input vec_t v, input int idx);
    if (v.is_d) begin
      dmem_valid = 1'b1; dmem_addr = v.addr; dmem_wdata = v.wdata;
      dmem_mask = v.mask; dmem_we = v.we;
    end else begin
      imem_valid = 1'b1; imem_addr = v.addr;
      dmem_wdata = v.wdata; dmem_mask = v.mask; dmem_we = v.we;
    end
    @(negedge clk);
    chk($sformatf("v%0d mem_valid", idx), 64'(mem_valid), 64'(1'b1));
    chk($sformatf("v%0d mem_addr", idx), 64'(mem_addr), 64'(v.addr));
    chk($sformatf("v%0d mem_wdata", idx), 64'(mem_wdata), 64'(v.exp_wdata));
    chk($sformatf("v%0d mem_mask", idx), 64'(mem_mask), 64'(v.exp_mask));
    chk($sformatf("v%0d mem_we", idx), 64'(mem_we), 64'(v.exp_we));
    chk($sformatf("v%0d owner_d", idx), 64'(owner_d), 64'(v.is_d));
    for (int k = 0; k < v.delay; k++) begin
      chk($sformatf("v%0d wait acks", idx), 64'({imem_ack, dmem_ack, mem_valid}), 64'(3'b001));
      @(negedge clk);
    end
    chk($sformatf("v%0d addr hold", idx), 64'(mem_addr), 64'(v.addr));
    mem_ack = 1'b1; mem_rdata = v.rdata;
    #1;
    if (v.is_d) begin
      chk($sformatf("v%0d dmem_ack", idx), 64'(dmem_ack), 64'(1'b1));
      chk($sformatf("v%0d dmem_rdata", idx), 64'(dmem_rdata), 64'(v.rdata));
      chk($sformatf("v%0d imem idle", idx), 64'({imem_ack, imem_rdata}), 64'(0));
    end else begin
      chk($sformatf("v%0d imem_ack", idx), 64'(imem_ack), 64'(1'b1));
      chk($sformatf("v%0d imem_rdata", idx), 64'(imem_rdata), 64'(v.rdata));
      chk($sformatf("v%0d dmem idle", idx), 64'({dmem_ack, dmem_rdata}), 64'(0));
    end
    imem_valid = 1'b0; dmem_valid = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk($sformatf("v%0d back idle", idx), 64'({mem_valid, busy, imem_ack, dmem_ack}), 64'(0));
    chk($sformatf("v%0d owner hold", idx), 64'(owner_d), 64'(v.is_d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_pat;
    logic       ed;

    vecs[0] = '{is_d:1'b0, addr:32'h100, wdata:32'h0, mask:4'h0, we:1'b0, rdata:32'h00500093,
                delay:2, exp_wdata:32'h0, exp_mask:4'hF, exp_we:1'b0};
    vecs[1] = '{is_d:1'b1, addr:32'h2000, wdata:32'hDEADBEEF, mask:4'h3, we:1'b1, rdata:32'h0,
                delay:1, exp_wdata:32'hDEADBEEF, exp_mask:4'h3, exp_we:1'b1};
    vecs[2] = '{is_d:1'b1, addr:32'h2004, wdata:32'h0, mask:4'hF, we:1'b0, rdata:32'hCAFEF00D,
                delay:0, exp_wdata:32'h0, exp_mask:4'hF, exp_we:1'b0};
    vecs[3] = '{is_d:1'b0, addr:32'h104, wdata:32'h55AA55AA, mask:4'h5, we:1'b1, rdata:32'h12345678,
                delay:0, exp_wdata:32'h0, exp_mask:4'hF, exp_we:1'b0};
    vecs[4] = '{is_d:1'b1, addr:32'hFFFFFFFC, wdata:32'h01020304, mask:4'h8, we:1'b1, rdata:32'h0,
                delay:3, exp_wdata:32'h01020304, exp_mask:4'h8, exp_we:1'b1};

    imem_addr = '0; imem_valid = 1'b0; dmem_addr = '0; dmem_valid = 1'b0;
    dmem_wdata = '0; dmem_mask = '0; dmem_we = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    chk("reset outs", 64'({mem_valid, busy, owner_d, imem_ack, dmem_ack}), 64'(0));
    chk("reset payload", 64'({mem_addr, mem_mask, mem_we}), 64'(0));
    chk("reset wdata", 64'(mem_wdata), 64'(0));

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // mem_ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'h77;
    #1;
    chk("idle ack ignored", 64'({imem_ack, dmem_ack}), 64'(0));
    chk("idle rdata zero", 64'({imem_rdata, dmem_rdata}), 64'(0));
    @(negedge clk);
    chk("idle stays idle", 64'({mem_valid, busy}), 64'(0));
    mem_ack = 1'b0;

    // requester drops valid and moves addr mid-grant
    imem_valid = 1'b1; imem_addr = 32'h40;
    @(negedge clk);
    chk("mid addr 0x40", 64'(mem_addr), 64'(32'h40));
    imem_valid = 1'b0; imem_addr = 32'h80;
    @(negedge clk);
    chk("mid hold valid", 64'(mem_valid), 64'(1'b1));
    chk("mid hold addr", 64'(mem_addr), 64'(32'h40));
    @(negedge clk);
    chk("mid hold addr2", 64'(mem_addr), 64'(32'h40));
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    #1;
    chk("mid imem_ack", 64'(imem_ack), 64'(1'b1));
    chk("mid imem_rdata", 64'(imem_rdata), 64'(32'h0BADF00D));
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("mid done", 64'({mem_valid, imem_ack}), 64'(0));

    // contention over four back-to-back transactions
`ifdef ORION_ARB_ROUND_ROBIN_EN
    exp_pat = 4'b0101;
`else
    exp_pat = 4'b1111;
`endif
    do_reset();
    imem_valid = 1'b1; imem_addr = 32'h10;
    dmem_valid = 1'b1; dmem_addr = 32'h20; dmem_we = 1'b0; dmem_mask = 4'hF;
    for (int k = 0; k < 4; k++) begin
      ed = exp_pat[k];
      @(negedge clk);
      chk($sformatf("arb%0d valid", k), 64'(mem_valid), 64'(1'b1));
      chk($sformatf("arb%0d owner_d", k), 64'(owner_d), 64'(ed));
      chk($sformatf("arb%0d addr", k), 64'(mem_addr), ed ? 64'(32'h20) : 64'(32'h10));
      mem_ack = 1'b1; mem_rdata = 32'(k);
      #1;
      chk($sformatf("arb%0d acks", k), 64'({imem_ack, dmem_ack}), ed ? 64'(2'b01) : 64'(2'b10));
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk($sformatf("arb%0d gap", k), 64'(mem_valid), 64'(1'b0));
    end
    imem_valid = 1'b0; dmem_valid = 1'b0;
    @(negedge clk);

    // reset during a data grant abandons it
    dmem_valid = 1'b1; dmem_addr = 32'h3000; dmem_we = 1'b1; dmem_wdata = 32'h1111;
    @(negedge clk);
    chk("rstg granted", 64'({mem_valid, owner_d}), 64'(2'b11));
    rst = 1'b1; dmem_valid = 1'b0;
    #1;
    chk("rstg no ack", 64'(dmem_ack), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstg idle", 64'({mem_valid, busy, owner_d, dmem_ack}), 64'(0));
    chk("rstg payload", 64'({mem_addr, mem_we}), 64'(0));
    @(negedge clk);
    chk("rstg stays idle", 64'({mem_valid, dmem_ack}), 64'(0));

    // mem_ack coincident with reset still acks that cycle
    imem_valid = 1'b1; imem_addr = 32'h200;
    @(negedge clk);
    imem_valid = 1'b0;
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hABCD;
    #1;
    chk("rstack imem_ack", 64'({imem_ack, imem_rdata}), 64'({1'b1, 32'hABCD}));
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    chk("rstack idle", 64'({mem_valid, busy, imem_ack}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
